// File: rtl/alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_sequencer
// Description : Front end between board I/O and an external combinational
//               ALU. Four raw push-buttons are synchronised, debounced and
//               rising-edge detected. Their pulses load operand A, operand B
//               and the opcode from the switches, or clear everything. A small
//               FSM captures the ALU result onto the LEDs once all three
//               values are loaded, and again after every later load.
// Ports       : i_clk, i_reset (async, active low)
//               i_switches         - operand / opcode source
//               i_btn_set_operand1 - raw button, load A
//               i_btn_set_operand2 - raw button, load B
//               i_btn_set_operator - raw button, load opcode
//               i_btn_clear        - raw button, clear all registers
//               i_alu_result       - combinational ALU output
//               o_data_a/o_data_b/o_op - registered ALU inputs
//               o_leds             - registered result display
//               o_loaded           - {op, B, A} loaded flags
//               o_result_valid     - o_leds matches current A/B/op
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_sequencer #(
  parameter int NB_DATA         = 8,
  parameter int NB_OP           = 6,
  parameter int NB_OUT          = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_switches,
  input  logic               i_btn_set_operand1,
  input  logic               i_btn_set_operand2,
  input  logic               i_btn_set_operator,
  input  logic               i_btn_clear,
  input  logic [NB_OUT-1:0]  i_alu_result,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_OUT-1:0]  o_leds,
  output logic [2:0]         o_loaded,
  output logic               o_result_valid
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1 before the level flips.
  localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] c_S_WAIT = 2'd0;
  localparam logic [1:0] c_S_EVAL = 2'd1;
  localparam logic [1:0] c_S_SHOW = 2'd2;

  // Button order: [0]=A, [1]=B, [2]=op, [3]=clear
  logic [3:0] w_btn_raw;
  logic [3:0] w_pulse;

  assign w_btn_raw = {i_btn_clear, i_btn_set_operator,
                      i_btn_set_operand2, i_btn_set_operand1};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      logic               r_sync1;
      logic               r_sync2;
      logic               r_stable;
      logic               r_stable_d;
      logic               r_pulse;
      logic [c_CNT_W-1:0] r_cnt;

      always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
          r_sync1    <= 1'b0;
          r_sync2    <= 1'b0;
          r_stable   <= 1'b0;
          r_stable_d <= 1'b0;
          r_pulse    <= 1'b0;
          r_cnt      <= '0;
        end else begin
          r_sync1    <= w_btn_raw[gi];
          r_sync2    <= r_sync1;
          r_stable_d <= r_stable;
          // Registered edge detect keeps the pulse off the debounce path.
          r_pulse    <= r_stable & ~r_stable_d;
          if (r_sync2 == r_stable) begin
            r_cnt <= '0;
          end else if (r_cnt == c_CNT_LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_pulse[gi] = r_pulse;
    end
  endgenerate

  logic [1:0] r_state;
  logic       w_any_load;
  logic [2:0] w_loaded_next;

  assign w_any_load    = |w_pulse[2:0];
  assign w_loaded_next = o_loaded | w_pulse[2:0];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_data_a       <= '0;
      o_data_b       <= '0;
      o_op           <= '0;
      o_leds         <= '0;
      o_loaded       <= 3'b000;
      o_result_valid <= 1'b0;
      r_state        <= c_S_WAIT;
    end else if (w_pulse[3]) begin
      // Clear overrides any load arriving on the same edge.
      o_data_a       <= '0;
      o_data_b       <= '0;
      o_op           <= '0;
      o_leds         <= '0;
      o_loaded       <= 3'b000;
      o_result_valid <= 1'b0;
      r_state        <= c_S_WAIT;
    end else begin
      if (w_pulse[0]) o_data_a <= i_switches;
      if (w_pulse[1]) o_data_b <= i_switches;
      if (w_pulse[2]) o_op     <= i_switches[NB_OP-1:0];
      o_loaded <= w_loaded_next;

      case (r_state)
        c_S_WAIT: begin
          o_result_valid <= 1'b0;
          if (w_loaded_next == 3'b111) r_state <= c_S_EVAL;
        end
        c_S_EVAL: begin
          o_leds <= i_alu_result;
          // A load landing now makes this capture stale: re-evaluate.
          if (w_any_load) begin
            o_result_valid <= 1'b0;
          end else begin
            o_result_valid <= 1'b1;
            r_state        <= c_S_SHOW;
          end
        end
        c_S_SHOW: begin
          if (w_any_load) begin
            o_result_valid <= 1'b0;
            r_state        <= c_S_EVAL;
          end
        end
        default: r_state <= c_S_WAIT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_sequencer
// Description : Directed bench for alu_operand_sequencer with a behavioural
//               add/subtract ALU model (DEBOUNCE_CYCLES = 4). A press set up
//               just after edge E is first sampled at E+1, pulses at E+7 and
//               loads its register at E+8; the result shows at E+9.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  sw = '0;
  logic [3:0]  btn = '0;  // [0]=A [1]=B [2]=op [3]=clear
  logic [15:0] alu_res;
  logic [7:0]  data_a, data_b;
  logic [5:0]  op;
  logic [15:0] leds;
  logic [2:0]  loaded;
  logic        valid;

  int total = 0;
  int bad   = 0;

  alu_operand_sequencer #(
    .NB_DATA(8), .NB_OP(6), .NB_OUT(16), .DEBOUNCE_CYCLES(4)
  ) dut (
    .i_clk              (clk),
    .i_reset            (rst_n),
    .i_switches         (sw),
    .i_btn_set_operand1 (btn[0]),
    .i_btn_set_operand2 (btn[1]),
    .i_btn_set_operator (btn[2]),
    .i_btn_clear        (btn[3]),
    .i_alu_result       (alu_res),
    .o_data_a           (data_a),
    .o_data_b           (data_b),
    .o_op               (op),
    .o_leds             (leds),
    .o_loaded           (loaded),
    .o_result_valid     (valid)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_res = '0;
    case (op)
      6'b100000: alu_res = {{8{data_a[7]}}, data_a} + {{8{data_b[7]}}, data_b};
      6'b100010: alu_res = {{8{data_a[7]}}, data_a} - {{8{data_b[7]}}, data_b};
      default:   alu_res = '0;
    endcase
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Press button idx with switch value v and run n edges.
  task automatic press(input int idx, input logic [7:0] v, input int n);
    sw       = v;
    btn[idx] = 1'b1;
    step(n);
  endtask

  task automatic release_all();
    btn = '0;
    step(8);
  endtask

  // Load 5, 3, add from a freshly reset/cleared state.
  task automatic run_s1(input string pfx);
    press(0, 8'h05, 8);
    chk({pfx, "_loadA"}, {53'd0, loaded, data_a}, {53'd0, 3'b001, 8'h05});
    release_all();
    press(1, 8'h03, 8);
    chk({pfx, "_loadB"}, {53'd0, loaded, data_b}, {53'd0, 3'b011, 8'h03});
    release_all();
    press(2, 8'h20, 7);
    chk({pfx, "_op_before_edge"}, {61'd0, loaded}, {61'd0, 3'b011});
    step(1);
    chk({pfx, "_op_reg_edge"}, {38'd0, loaded, op, leds, valid},
        {38'd0, 3'b111, 6'b100000, 16'd0, 1'b0});
    step(1);
    chk({pfx, "_result"}, {47'd0, leds, valid}, {47'd0, 16'd8, 1'b1});
    release_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(2);
    chk("reset_outputs", {22'd0, data_a, data_b, op, leds, loaded, valid}, 64'd0);
    rst_n = 1'b1;
    step(1);

    // 1. basic load sequence and add
    run_s1("s1");

    // 2. reload A while showing
    press(0, 8'h25, 8);
    chk("s2_reg_edge", {31'd0, data_a, leds, valid}, {31'd0, 8'h25, 16'd8, 1'b0});
    step(1);
    chk("s2_result", {47'd0, leds, valid}, {47'd0, 16'd40, 1'b1});
    release_all();

    // 3. bounce: 3 high, 1 low, 3 high -> no pulse
    sw = 8'h11;
    btn[0] = 1'b1; step(3);
    btn[0] = 1'b0; step(1);
    btn[0] = 1'b1; step(3);
    btn[0] = 1'b0; step(10);
    chk("s3_bounce_ignored", {39'd0, data_a, leds, valid}, {39'd0, 8'h25, 16'd40, 1'b1});
    // clean 6-cycle hold -> exactly one pulse
    press(0, 8'h07, 6);
    btn[0] = 1'b0;
    step(2);
    chk("s3_hold_loaded", {55'd0, data_a, valid}, {55'd0, 8'h07, 1'b0});
    sw = 8'h09;
    step(1);
    chk("s3_hold_result", {47'd0, leds, valid}, {47'd0, 16'd10, 1'b1});
    step(10);
    chk("s3_single_pulse", {56'd0, data_a}, {56'd0, 8'h07});

    // 4. clear and load-B in the same cycle
    sw  = 8'h44;
    btn = 4'b1010;
    step(8);
    chk("s4_clear_wins", {22'd0, data_a, data_b, op, leds, loaded, valid}, 64'd0);
    release_all();

    // 5. subtract with negative result; valid stays low until all loaded
    press(0, 8'h03, 8);
    chk("s5_wait_after_clear", {60'd0, loaded, valid}, {60'd0, 3'b001, 1'b0});
    release_all();
    press(1, 8'h05, 8);
    release_all();
    press(2, 8'h22, 9);
    chk("s5_negative", {47'd0, leds, valid}, {47'd0, 16'hFFFE, 1'b1});
    release_all();

    // 6. async reset while in S_EVAL
    press(0, 8'h04, 8);
    chk("s6_in_eval", {39'd0, data_a, leds, valid}, {39'd0, 8'h04, 16'hFFFE, 1'b0});
    #2;
    rst_n = 1'b0;
    btn   = '0;
    #1;
    chk("s6_async_reset", {22'd0, data_a, data_b, op, leds, loaded, valid}, 64'd0);
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("s6_after_release", {22'd0, data_a, data_b, op, leds, loaded, valid}, 64'd0);
    run_s1("s6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
